// File: rtl/fractal_sync_req_tx.sv
// Barrier initiator: forwards one core barrier request up the tree and waits for its wake-up.
// Define FRACTAL_SYNC_TIMEOUT_EN to bound the wait state with a TIMEOUT_CYCLES limit.
module fractal_sync_req_tx #(
  parameter int LEVEL_WIDTH    = 1,
  parameter int ID_WIDTH       = 1,
  parameter int MAX_LEVEL      = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [LEVEL_WIDTH-1:0] req_level_i,
  input  logic [ID_WIDTH-1:0]    req_id_i,
  output logic                   sync_valid_o,
  input  logic                   sync_ready_i,
  output logic [LEVEL_WIDTH-1:0] sync_level_o,
  output logic [ID_WIDTH-1:0]    sync_id_o,
  input  logic                   wake_valid_i,
  input  logic [LEVEL_WIDTH-1:0] wake_level_i,
  input  logic [ID_WIDTH-1:0]    wake_id_i,
  input  logic                   wake_err_i,
  output logic                   done_o,
  output logic                   error_o,
  output logic                   busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                 r_state;
  logic                   r_req_ready;
  logic                   r_sync_valid;
  logic                   r_done;
  logic                   r_error;
  logic                   r_busy;
  logic [LEVEL_WIDTH-1:0] r_level;
  logic [ID_WIDTH-1:0]    r_id;

  logic w_level_illegal;
  logic w_wake_match;
  logic w_timeout;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_param_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  assign w_level_illegal = (32'(req_level_i) > $unsigned(MAX_LEVEL));
  assign w_wake_match    = wake_valid_i && (wake_level_i == r_level) && (wake_id_i == r_id);

`ifdef FRACTAL_SYNC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_cnt_next;

  // Fires at the end of the TIMEOUT_CYCLES-th wait cycle.
  assign w_wait_cnt_next = r_wait_cnt + CNT_W'(1);
  assign w_timeout       = (w_wait_cnt_next == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wait_cnt <= '0;
    end else if (r_state != S_WAIT) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= w_wait_cnt_next;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Barrier FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_sync_valid <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_busy       <= 1'b0;
      r_level      <= '0;
      r_id         <= '0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_level     <= req_level_i;
            r_id        <= req_id_i;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (w_level_illegal) begin
              r_state <= S_RESP;
              r_done  <= 1'b1;
              r_error <= 1'b1;
            end else begin
              r_state      <= S_SEND;
              r_sync_valid <= 1'b1;
            end
          end
        end
        S_SEND: begin
          if (sync_ready_i) begin
            r_sync_valid <= 1'b0;
            r_state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A matching wake wins over a simultaneous timeout.
          if (w_wake_match) begin
            r_state <= S_RESP;
            r_done  <= 1'b1;
            r_error <= wake_err_i;
          end else if (w_timeout) begin
            r_state <= S_RESP;
            r_done  <= 1'b1;
            r_error <= 1'b1;
          end
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_req_ready  <= 1'b1;
          r_sync_valid <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o  = r_req_ready;
  assign sync_valid_o = r_sync_valid;
  assign sync_level_o = r_level;
  assign sync_id_o    = r_id;
  assign done_o       = r_done;
  assign error_o      = r_error;
  assign busy_o       = r_busy;

endmodule

// File: tb/tb_fractal_sync_req_tx.sv
// Directed self-checking bench for fractal_sync_req_tx (LEVEL_WIDTH=2, ID_WIDTH=2, MAX_LEVEL=1, TIMEOUT_CYCLES=8).
module tb_fractal_sync_req_tx;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       req_valid_i;
  logic       req_ready_o;
  logic [1:0] req_level_i;
  logic [1:0] req_id_i;
  logic       sync_valid_o;
  logic       sync_ready_i;
  logic [1:0] sync_level_o;
  logic [1:0] sync_id_o;
  logic       wake_valid_i;
  logic [1:0] wake_level_i;
  logic [1:0] wake_id_i;
  logic       wake_err_i;
  logic       done_o;
  logic       error_o;
  logic       busy_o;

  int total = 0;
  int bad   = 0;

  fractal_sync_req_tx #(
    .LEVEL_WIDTH(2), .ID_WIDTH(2), .MAX_LEVEL(1), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_level_i(req_level_i), .req_id_i(req_id_i),
    .sync_valid_o(sync_valid_o), .sync_ready_i(sync_ready_i),
    .sync_level_o(sync_level_o), .sync_id_o(sync_id_o),
    .wake_valid_i(wake_valid_i), .wake_level_i(wake_level_i),
    .wake_id_i(wake_id_i), .wake_err_i(wake_err_i),
    .done_o(done_o), .error_o(error_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Accept a legal request with immediate tree ready; returns with the DUT in WAIT.
  task automatic start_barrier(input logic [1:0] lvl, input logic [1:0] id);
    req_valid_i = 1'b1; req_level_i = lvl; req_id_i = id; sync_ready_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    tick();
    sync_ready_i = 1'b0;
  endtask

  task automatic wake(input logic [1:0] lvl, input logic [1:0] id, input logic err);
    wake_valid_i = 1'b1; wake_level_i = lvl; wake_id_i = id; wake_err_i = err;
    tick();
    wake_valid_i = 1'b0; wake_err_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(); tick();
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready_o); end
    total++; if (sync_valid_o !== 1'b0) begin bad++; $display("FAIL reset_sync_valid got=%0b exp=0", sync_valid_o); end
    total++; if (sync_level_o !== 2'd0 || sync_id_o !== 2'd0) begin bad++; $display("FAIL reset_level_id got=%0d/%0d exp=0/0", sync_level_o, sync_id_o); end
    total++; if (done_o !== 1'b0 || error_o !== 1'b0) begin bad++; $display("FAIL reset_done_err got=%0b/%0b exp=0/0", done_o, error_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy_o); end
    rst_i = 1'b0;
    tick();
    total++; if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin bad++; $display("FAIL idle_after_reset got=%0b/%0b exp=1/0", req_ready_o, busy_o); end
  endtask

  task automatic test_normal();
    req_valid_i = 1'b1; req_level_i = 2'd1; req_id_i = 2'd0; sync_ready_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    total++; if (sync_valid_o !== 1'b1) begin bad++; $display("FAIL normal_sync_valid got=%0b exp=1", sync_valid_o); end
    total++; if (sync_level_o !== 2'd1 || sync_id_o !== 2'd0) begin bad++; $display("FAIL normal_level_id got=%0d/%0d exp=1/0", sync_level_o, sync_id_o); end
    total++; if (req_ready_o !== 1'b0 || busy_o !== 1'b1) begin bad++; $display("FAIL normal_ready_busy got=%0b/%0b exp=0/1", req_ready_o, busy_o); end
    tick();
    sync_ready_i = 1'b0;
    total++; if (sync_valid_o !== 1'b0) begin bad++; $display("FAIL normal_sync_drop got=%0b exp=0", sync_valid_o); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (done_o !== 1'b0 || sync_valid_o !== 1'b0) begin bad++; $display("FAIL normal_wait_%0d got=%0b/%0b exp=0/0", i, done_o, sync_valid_o); end
    end
    wake(2'd1, 2'd0, 1'b0);
    total++; if (done_o !== 1'b1 || error_o !== 1'b0) begin bad++; $display("FAIL normal_done got=%0b/%0b exp=1/0", done_o, error_o); end
    tick();
    total++; if (done_o !== 1'b0 || req_ready_o !== 1'b1 || busy_o !== 1'b0) begin bad++; $display("FAIL normal_return got=%0b/%0b/%0b exp=0/1/0", done_o, req_ready_o, busy_o); end
  endtask

  task automatic test_backpressure();
    req_valid_i = 1'b1; req_level_i = 2'd1; req_id_i = 2'd0; sync_ready_i = 1'b0;
    tick();
    req_valid_i = 1'b0; req_level_i = 2'd3; req_id_i = 2'd3;
    for (int i = 0; i < 3; i++) begin
      total++; if (sync_valid_o !== 1'b1 || sync_level_o !== 2'd1 || sync_id_o !== 2'd0) begin bad++; $display("FAIL bp_hold_%0d got=%0b/%0d/%0d exp=1/1/0", i, sync_valid_o, sync_level_o, sync_id_o); end
      tick();
    end
    sync_ready_i = 1'b1;
    total++; if (sync_valid_o !== 1'b1) begin bad++; $display("FAIL bp_hold_last got=%0b exp=1", sync_valid_o); end
    tick();
    sync_ready_i = 1'b0;
    total++; if (sync_valid_o !== 1'b0) begin bad++; $display("FAIL bp_sync_drop got=%0b exp=0", sync_valid_o); end
    wake(2'd1, 2'd1, 1'b0);
    total++; if (done_o !== 1'b0 || busy_o !== 1'b1) begin bad++; $display("FAIL bp_wrong_id got=%0b/%0b exp=0/1", done_o, busy_o); end
    wake(2'd0, 2'd0, 1'b1);
    total++; if (done_o !== 1'b0 || error_o !== 1'b0) begin bad++; $display("FAIL bp_wrong_level got=%0b/%0b exp=0/0", done_o, error_o); end
    wake(2'd1, 2'd0, 1'b0);
    total++; if (done_o !== 1'b1 || error_o !== 1'b0) begin bad++; $display("FAIL bp_match got=%0b/%0b exp=1/0", done_o, error_o); end
    tick();
  endtask

  task automatic test_illegal_and_err();
    req_valid_i = 1'b1; req_level_i = 2'd2; req_id_i = 2'd1; sync_ready_i = 1'b1;
    tick();
    req_valid_i = 1'b0; sync_ready_i = 1'b0;
    total++; if (sync_valid_o !== 1'b0) begin bad++; $display("FAIL illegal_no_sync got=%0b exp=0", sync_valid_o); end
    total++; if (done_o !== 1'b1 || error_o !== 1'b1) begin bad++; $display("FAIL illegal_done_err got=%0b/%0b exp=1/1", done_o, error_o); end
    tick();
    total++; if (done_o !== 1'b0 || sync_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin bad++; $display("FAIL illegal_return got=%0b/%0b/%0b exp=0/0/1", done_o, sync_valid_o, req_ready_o); end
    start_barrier(2'd0, 2'd3);
    wake(2'd0, 2'd3, 1'b1);
    total++; if (done_o !== 1'b1 || error_o !== 1'b1) begin bad++; $display("FAIL wake_err got=%0b/%0b exp=1/1", done_o, error_o); end
    tick();
    total++; if (error_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL wake_err_return got=%0b/%0b exp=0/0", error_o, busy_o); end
  endtask

  task automatic test_back_to_back();
    start_barrier(2'd1, 2'd2);
    wake(2'd1, 2'd2, 1'b0);
    req_valid_i = 1'b1; req_level_i = 2'd0; req_id_i = 2'd1; sync_ready_i = 1'b0;
    total++; if (done_o !== 1'b1 || req_ready_o !== 1'b0) begin bad++; $display("FAIL b2b_resp got=%0b/%0b exp=1/0", done_o, req_ready_o); end
    tick();
    total++; if (done_o !== 1'b0 || req_ready_o !== 1'b1 || sync_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%0b/%0b/%0b exp=0/1/0", done_o, req_ready_o, sync_valid_o); end
    tick();
    req_valid_i = 1'b0;
    total++; if (sync_valid_o !== 1'b1 || sync_level_o !== 2'd0 || sync_id_o !== 2'd1) begin bad++; $display("FAIL b2b_second got=%0b/%0d/%0d exp=1/0/1", sync_valid_o, sync_level_o, sync_id_o); end
    sync_ready_i = 1'b1;
    wake(2'd0, 2'd1, 1'b0);
    sync_ready_i = 1'b0;
    total++; if (done_o !== 1'b0 || sync_valid_o !== 1'b0 || busy_o !== 1'b1) begin bad++; $display("FAIL b2b_wake_in_send got=%0b/%0b/%0b exp=0/0/1", done_o, sync_valid_o, busy_o); end
    tick();
    total++; if (done_o !== 1'b0 || busy_o !== 1'b1) begin bad++; $display("FAIL b2b_still_wait got=%0b/%0b exp=0/1", done_o, busy_o); end
    wake(2'd0, 2'd1, 1'b0);
    total++; if (done_o !== 1'b1 || error_o !== 1'b0) begin bad++; $display("FAIL b2b_done got=%0b/%0b exp=1/0", done_o, error_o); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    start_barrier(2'd1, 2'd3);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    total++; if (busy_o !== 1'b0 || req_ready_o !== 1'b1 || sync_level_o !== 2'd0 || sync_id_o !== 2'd0) begin bad++; $display("FAIL rstwait_idle got=%0b/%0b/%0d/%0d exp=0/1/0/0", busy_o, req_ready_o, sync_level_o, sync_id_o); end
    wake(2'd1, 2'd3, 1'b0);
    total++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL rstwait_stale_wake got=%0b/%0b exp=0/0", done_o, busy_o); end
  endtask

  task automatic test_timeout();
`ifdef FRACTAL_SYNC_TIMEOUT_EN
    start_barrier(2'd1, 2'd1);
    for (int i = 1; i < 8; i++) begin
      tick();
      total++; if (done_o !== 1'b0 || busy_o !== 1'b1) begin bad++; $display("FAIL to_wait_%0d got=%0b/%0b exp=0/1", i, done_o, busy_o); end
    end
    tick();
    total++; if (done_o !== 1'b1 || error_o !== 1'b1) begin bad++; $display("FAIL to_expire got=%0b/%0b exp=1/1", done_o, error_o); end
    tick();
    start_barrier(2'd0, 2'd2);
    for (int i = 1; i < 8; i++) tick();
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL to_before_limit got=%0b exp=0", done_o); end
    wake(2'd0, 2'd2, 1'b0);
    total++; if (done_o !== 1'b1 || error_o !== 1'b0) begin bad++; $display("FAIL to_wake_priority got=%0b/%0b exp=1/0", done_o, error_o); end
    tick();
`else
    start_barrier(2'd1, 2'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      total++; if (done_o !== 1'b0 || busy_o !== 1'b1) begin bad++; $display("FAIL nto_wait_%0d got=%0b/%0b exp=0/1", i, done_o, busy_o); end
    end
    wake(2'd1, 2'd1, 1'b0);
    total++; if (done_o !== 1'b1 || error_o !== 1'b0) begin bad++; $display("FAIL nto_done got=%0b/%0b exp=1/0", done_o, error_o); end
    tick();
`endif
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_level_i = 2'd0; req_id_i = 2'd0;
    sync_ready_i = 1'b0; wake_valid_i = 1'b0; wake_level_i = 2'd0;
    wake_id_i = 2'd0; wake_err_i = 1'b0;
    test_reset();
    test_normal();
    test_backpressure();
    test_illegal_and_err();
    test_back_to_back();
    test_reset_mid_wait();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
